// File: rtl/fp_pkg.sv
// Shared types and format constants for the pipelined floating-point multiplier.
package fp_pkg;

    // Widest fields any supported format may need: stage payload fields are sized
    // to these and sliced down to the configured format inside each module.
    localparam int unsigned FP_EXP_MAXW = 16;
    localparam int unsigned FP_SIG_MAXW = 64;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic                          sign;
        logic signed [FP_EXP_MAXW-1:0] exp;
        fp_class_e                     cls;
        logic [FP_SIG_MAXW-1:0]        sig;
    } fp_stage_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // {exp=all ones, man=0}, right-aligned, sign bit excluded.
    function automatic logic [FP_SIG_MAXW-1:0] fp_inf(input int exp_w, input int man_w);
        logic [FP_SIG_MAXW-1:0] ones;
        ones = (FP_SIG_MAXW'(1) << exp_w) - FP_SIG_MAXW'(1);
        return ones << man_w;
    endfunction

    function automatic logic [FP_SIG_MAXW-1:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (FP_SIG_MAXW'(1) << (man_w - 1));
    endfunction

    // One below inf: exponent all-ones minus one, mantissa all ones.
    function automatic logic [FP_SIG_MAXW-1:0] fp_max_finite(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) - FP_SIG_MAXW'(1);
    endfunction

    // Subnormals (exp field 0) are classed as zero regardless of mantissa.
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic man_zero);
        if (exp_zero)
            return FP_ZERO;
        else if (exp_ones)
            return man_zero ? FP_INF : FP_NAN;
        else
            return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational normalise / round / pack of a significand product, with
// special-value and exception handling.
module fp_round_norm
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W     = 5,
    parameter int unsigned MAN_W     = 10,
    parameter int unsigned ROUND_RNE = 1,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                     sign_i,
    input  logic signed [EXP_W+1:0]  exp_i,
    input  logic [1:0]               cls_i,
    input  logic [2*MAN_W+1:0]       sig_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic                     ovf_o,
    output logic                     unf_o,
    output logic                     inv_o
);

    localparam int unsigned PW      = 2 * MAN_W + 2;
    localparam int unsigned FW      = EXP_W + MAN_W + 1;
    localparam int          EXP_MAX = (1 << EXP_W) - 1;

    localparam logic [FP_SIG_MAXW-1:0] INF_FULL = fp_inf(EXP_W, MAN_W);
    localparam logic [FP_SIG_MAXW-1:0] NAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [FP_SIG_MAXW-1:0] MAX_FULL = fp_max_finite(EXP_W, MAN_W);

    fp_class_e        cls;
    logic [PW-1:0]    norm;
    logic [MAN_W-1:0] mant;
    logic             guard;
    logic             sticky;
    logic             inc;
    logic [MAN_W:0]   mant_r;
    int               e_final;

    assign cls = fp_class_e'(cls_i);

    // Normalise to 1.x, round on guard/sticky, then resolve specials and range.
    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        unf_o    = 1'b0;
        inv_o    = 1'b0;

        // Product lies in [1,4); leading one ends up at PW-1 either way.
        norm    = sig_i[PW-1] ? sig_i : {sig_i[PW-2:0], 1'b0};
        mant    = norm[PW-2:MAN_W+1];
        guard   = norm[MAN_W];
        sticky  = |norm[MAN_W-1:0];
        inc     = (ROUND_RNE != 0) && guard && (sticky || mant[0]);
        mant_r  = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
        // A carry out of rounding leaves the low mantissa bits at zero, i.e. 1.0 x 2.
        e_final = int'(exp_i) + int'(sig_i[PW-1]) + int'(mant_r[MAN_W]);

        case (cls)
            FP_NAN: begin
                result_o = NAN_FULL[FW-1:0];
                inv_o    = 1'b1;
            end
            FP_INF:  result_o = {sign_i, INF_FULL[FW-2:0]};
            FP_ZERO: result_o = {sign_i, {(FW-1){1'b0}}};
            default: begin
                if (e_final >= EXP_MAX) begin
                    ovf_o    = 1'b1;
                    result_o = (SATURATE != 0) ? {sign_i, MAX_FULL[FW-2:0]}
                                               : {sign_i, INF_FULL[FW-2:0]};
                end else if (e_final <= 0) begin
                    unf_o    = 1'b1;
                    result_o = {sign_i, {(FW-1){1'b0}}};
                end else begin
                    result_o = {sign_i, e_final[EXP_W-1:0], mant_r[MAN_W-1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier with valid/ready flow control:
// S1 unpack/classify, S2 significand multiply, S3 round/pack into the output register.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W     = 5,
    parameter int unsigned MAN_W     = 10,
    parameter int unsigned ROUND_RNE = 1,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] product,
    output logic                 flag_ovf,
    output logic                 flag_unf,
    output logic                 flag_inv
);

    localparam int unsigned FW   = EXP_W + MAN_W + 1;
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * SW;
    localparam int          BIAS = fp_bias(EXP_W);
    localparam logic signed [EXP_W+1:0] BIAS_E = BIAS[EXP_W+1:0];

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic take, adv1, adv2;

    fp_stage_t s1_d, s1_q, s2_d, s2_q;

    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        ma, mb;
    fp_class_e               ca, cb;
    logic signed [EXP_W+1:0] esum;
    logic [PW-1:0]           prod;

    logic [FW-1:0] res;
    logic          ovf, unf, inv;
    logic [FW-1:0] product_q;
    logic          ovf_q, unf_q, inv_q;

    // A stage moves forward when the stage after it is empty or draining.
    assign adv2     = v2_q && (!v3_q || out_ready);
    assign adv1     = v1_q && (!v2_q || adv2);
    assign in_ready = !v1_q || adv1;
    assign take     = in_valid && in_ready;

    assign out_valid = v3_q;
    assign product   = product_q;
    assign flag_ovf  = ovf_q;
    assign flag_unf  = unf_q;
    assign flag_inv  = inv_q;

    // Stage occupancy next-state.
    always_comb begin
        v1_d = take ? 1'b1 : (adv1 ? 1'b0 : v1_q);
        v2_d = adv1 ? 1'b1 : (adv2 ? 1'b0 : v2_q);
        v3_d = adv2 ? 1'b1 : ((v3_q && out_ready) ? 1'b0 : v3_q);
    end

    // S1: split fields, classify operands, resolve the result class, sum exponents.
    always_comb begin
        ea   = a[FW-2:MAN_W];
        eb   = b[FW-2:MAN_W];
        ma   = a[MAN_W-1:0];
        mb   = b[MAN_W-1:0];
        ca   = fp_classify(ea == '0, ea == '1, ma == '0);
        cb   = fp_classify(eb == '0, eb == '1, mb == '0);
        esum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;

        s1_d      = '0;
        s1_d.sign = a[FW-1] ^ b[FW-1];
        s1_d.exp  = {{(FP_EXP_MAXW-EXP_W-2){esum[EXP_W+1]}}, esum};
        // Both significands (hidden bit restored) travel in the one sig field.
        s1_d.sig  = {{(FP_SIG_MAXW-PW){1'b0}}, 1'b1, ma, 1'b1, mb};
        if (ca == FP_NAN || cb == FP_NAN ||
            (ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF))
            s1_d.cls = FP_NAN;
        else if (ca == FP_INF || cb == FP_INF)
            s1_d.cls = FP_INF;
        else if (ca == FP_ZERO || cb == FP_ZERO)
            s1_d.cls = FP_ZERO;
        else
            s1_d.cls = FP_NORM;
    end

    // S2: unsigned significand multiply; sign, exponent and class pass through.
    always_comb begin
        s2_d     = s1_q;
        prod     = {{SW{1'b0}}, s1_q.sig[PW-1:SW]} * {{SW{1'b0}}, s1_q.sig[SW-1:0]};
        s2_d.sig = {{(FP_SIG_MAXW-PW){1'b0}}, prod};
    end

    fp_round_norm #(
        .EXP_W    (EXP_W),
        .MAN_W    (MAN_W),
        .ROUND_RNE(ROUND_RNE),
        .SATURATE (SATURATE)
    ) u_round (
        .sign_i  (s2_q.sign),
        .exp_i   (s2_q.exp[EXP_W+1:0]),
        .cls_i   (s2_q.cls),
        .sig_i   (s2_q.sig[PW-1:0]),
        .result_o(res),
        .ovf_o   (ovf),
        .unf_o   (unf),
        .inv_o   (inv)
    );

    // Stage registers: each payload loads only when its stage accepts new data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (take)
                s1_q <= s1_d;
            if (adv1)
                s2_q <= s2_d;
            if (adv2) begin
                product_q <= res;
                ovf_q     <= ovf;
                unf_q     <= unf;
                inv_q     <= inv;
            end
        end
    end

endmodule
